// File: rtl/div_issue_ctrl.sv
// Issue/complete controller between the execute stage and an iterative
// 64-bit divider; resolves divide-by-zero and signed overflow locally.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        flush_i,
    input  logic [1:0]  div_op_i,
    input  logic        word_i,
    input  logic [63:0] rs1_i,
    input  logic [63:0] rs2_i,
    output logic        div_req_valid_o,
    output logic [63:0] div_op_1_o,
    output logic [63:0] div_op_2_o,
    output logic        div_sign_op_1_o,
    output logic        div_sign_op_2_o,
    input  logic [63:0] div_quotient_i,
    input  logic [63:0] div_remainder_i,
    input  logic        div_ready_i,
    input  logic        div_valid_i,
    output logic [63:0] result_o,
    output logic        result_valid_o,
    output logic        stall_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic        r_div_req;
    logic [63:0] r_op_1;
    logic [63:0] r_op_2;
    logic        r_sign;
    logic        r_is_rem;
    logic        r_word;
    logic [63:0] r_result;
    logic        r_result_valid;

    logic        w_signed;
    logic        w_is_rem;
    logic        w_accept;
    logic [63:0] w_op_1;
    logic [63:0] w_op_2;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_special;
    logic [63:0] w_special_res;
    logic [63:0] w_div_raw;
    logic [63:0] w_div_res;
    logic        w_stall;
    logic        w_unused_ready;

    // The divider handshake is purely valid-driven; ready carries no extra information here.
    assign w_unused_ready = div_ready_i;

    assign w_signed = ~div_op_i[0];
    assign w_is_rem = div_op_i[1];
    assign w_accept = (r_state == S_IDLE) && ex_valid_i && !flush_i;

    // Operand formation: W variants use the low word, extended according to signedness.
    always_comb begin
        w_op_1 = rs1_i;
        w_op_2 = rs2_i;
        if (word_i) begin
            if (w_signed) begin
                w_op_1 = {{32{rs1_i[31]}}, rs1_i[31:0]};
                w_op_2 = {{32{rs2_i[31]}}, rs2_i[31:0]};
            end else begin
                w_op_1 = {32'd0, rs1_i[31:0]};
                w_op_2 = {32'd0, rs2_i[31:0]};
            end
        end else begin
            w_op_1 = rs1_i;
            w_op_2 = rs2_i;
        end
    end

    // Special-case detection and the locally computed result.
    always_comb begin
        w_div_zero    = 1'b0;
        w_overflow    = 1'b0;
        w_special_res = 64'd0;
        if (word_i) begin
            w_div_zero = (rs2_i[31:0] == 32'd0);
            w_overflow = w_signed && (rs1_i[31:0] == 32'h8000_0000) && (rs2_i[31:0] == 32'hFFFF_FFFF);
        end else begin
            w_div_zero = (rs2_i == 64'd0);
            w_overflow = w_signed && (rs1_i == 64'h8000_0000_0000_0000) && (rs2_i == 64'hFFFF_FFFF_FFFF_FFFF);
        end
        if (w_div_zero) begin
            w_special_res = w_is_rem ? (word_i ? {{32{rs1_i[31]}}, rs1_i[31:0]} : rs1_i)
                                     : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_overflow) begin
            w_special_res = w_is_rem ? 64'd0 : (word_i ? {{32{rs1_i[31]}}, rs1_i[31:0]} : rs1_i);
        end else begin
            w_special_res = 64'd0;
        end
    end

    assign w_special = w_div_zero || w_overflow;
    assign w_div_raw = r_is_rem ? div_remainder_i : div_quotient_i;
    assign w_div_res = r_word ? {{32{w_div_raw[31]}}, w_div_raw[31:0]} : w_div_raw;

    // Main FSM and output registers; div_valid_i only matters in WAIT and DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_div_req      <= 1'b0;
            r_op_1         <= 64'd0;
            r_op_2         <= 64'd0;
            r_sign         <= 1'b0;
            r_is_rem       <= 1'b0;
            r_word         <= 1'b0;
            r_result       <= 64'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_div_req      <= 1'b0;
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_1   <= w_op_1;
                        r_op_2   <= w_op_2;
                        r_sign   <= w_signed;
                        r_is_rem <= w_is_rem;
                        r_word   <= word_i;
                        if (w_special) begin
                            r_result       <= w_special_res;
                            r_result_valid <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_div_req <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    // A flush coinciding with completion has nothing left to drain.
                    if (flush_i) begin
                        r_state <= div_valid_i ? S_IDLE : S_DRAIN;
                    end else if (div_valid_i) begin
                        r_result       <= w_div_res;
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (div_valid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall covers the whole in-flight window but releases in DONE.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = ex_valid_i;
            S_ISSUE: w_stall = 1'b1;
            S_WAIT:  w_stall = 1'b1;
            S_DRAIN: w_stall = 1'b1;
            S_DONE:  w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    assign div_req_valid_o = r_div_req;
    assign div_op_1_o      = r_op_1;
    assign div_op_2_o      = r_op_2;
    assign div_sign_op_1_o = r_sign;
    assign div_sign_op_2_o = r_sign;
    assign result_o        = r_result;
    // A flush landing on the DONE cycle must kill the strobe in that same cycle.
    assign result_valid_o  = r_result_valid && !flush_i;
    assign stall_o         = w_stall;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: transaction-level timing/result model,
// a 66-cycle divider model, and per-cycle comparison plus pinned literals.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, flush_i, word_i;
    logic [1:0]  div_op_i;
    logic [63:0] rs1_i, rs2_i;
    logic        div_req_valid_o, div_sign_op_1_o, div_sign_op_2_o;
    logic [63:0] div_op_1_o, div_op_2_o;
    logic [63:0] div_quotient_i, div_remainder_i;
    logic        div_ready_i, div_valid_i;
    logic [63:0] result_o;
    logic        result_valid_o, stall_o;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .flush_i(flush_i),
        .div_op_i(div_op_i), .word_i(word_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .div_req_valid_o(div_req_valid_o), .div_op_1_o(div_op_1_o), .div_op_2_o(div_op_2_o),
        .div_sign_op_1_o(div_sign_op_1_o), .div_sign_op_2_o(div_sign_op_2_o),
        .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
        .div_ready_i(div_ready_i), .div_valid_i(div_valid_i),
        .result_o(result_o), .result_valid_o(result_valid_o), .stall_o(stall_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: takes a request, completes 66 cycles later, reports valid while idle.
    logic        dv_busy;
    int          dv_cnt;
    logic [63:0] dv_q, dv_r;
    logic        dv_done;
    always @(posedge clk) begin
        if (rst) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
        end else if (!dv_busy && div_req_valid_o) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 0;
            if (div_op_2_o == 64'd0) begin
                dv_q <= 64'hFFFF_FFFF_FFFF_FFFF;
                dv_r <= div_op_1_o;
            end else if (div_sign_op_1_o && div_op_1_o == 64'h8000_0000_0000_0000 && div_op_2_o == 64'hFFFF_FFFF_FFFF_FFFF) begin
                dv_q <= div_op_1_o;
                dv_r <= 64'd0;
            end else if (div_sign_op_1_o) begin
                dv_q <= 64'($signed(div_op_1_o) / $signed(div_op_2_o));
                dv_r <= 64'($signed(div_op_1_o) % $signed(div_op_2_o));
            end else begin
                dv_q <= div_op_1_o / div_op_2_o;
                dv_r <= div_op_1_o % div_op_2_o;
            end
        end else if (dv_busy) begin
            if (dv_cnt == 65) dv_busy <= 1'b0;
            dv_cnt <= dv_cnt + 1;
        end
    end
    assign dv_done         = dv_busy && (dv_cnt == 65);
    assign div_valid_i     = !dv_busy || dv_done;
    assign div_ready_i     = !dv_busy;
    assign div_quotient_i  = dv_done ? dv_q : 64'hA5A5_A5A5_A5A5_A5A5;
    assign div_remainder_i = dv_done ? dv_r : 64'h5A5A_5A5A_5A5A_5A5A;

    // Architectural result of a divide/remainder instruction.
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic sgn, rem;
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        sgn = ~op[0];
        rem = op[1];
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (b32 == 32'd0) r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
            else if (sgn && rem) r32 = 32'($signed(a32) % $signed(b32));
            else if (sgn) r32 = 32'($signed(a32) / $signed(b32));
            else r32 = rem ? (a32 % b32) : (a32 / b32);
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = rem ? 64'd0 : a;
        else if (sgn && rem) r64 = 64'($signed(a) % $signed(b));
        else if (sgn) r64 = 64'($signed(a) / $signed(b));
        else r64 = rem ? (a % b) : (a / b);
        return r64;
    endfunction

    // Transaction model: cycle windows of the current instruction.
    int          m_blo = 1, m_bhi = 0, m_done = -1, m_req = -1, m_next = 0;
    logic        m_supp = 1'b0, m_issued = 1'b0, m_sign = 1'b0, chk_en = 1'b0;
    logic [63:0] m_res = 64'd0, m_op1 = 64'd0, m_op2 = 64'd0;

    // Pinned literal expectations: cycle, kind, value.
    int          lit_n = 0;
    int          lit_cyc [64];
    int          lit_sel [64];
    logic [63:0] lit_val [64];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @cycle %0d: got %b, want %b", nm, cyc, act, exp);
        end
    endtask

    logic c_busy, c_dn;
    // Compare process, sampling mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            c_busy = (cyc >= m_blo) && (cyc <= m_bhi);
            c_dn   = (cyc == m_done);
            chk1("stall", stall_o, c_busy || (!c_busy && !c_dn && ex_valid_i));
            chk1("req_pulse", div_req_valid_o, cyc == m_req);
            chk1("result_valid", result_valid_o, c_dn && !m_supp);
            if (c_dn && !m_supp) chk("result", result_o, m_res);
            if (c_busy && m_issued) begin
                chk("op1_hold", div_op_1_o, m_op1);
                chk("op2_hold", div_op_2_o, m_op2);
                chk1("sign1", div_sign_op_1_o, m_sign);
                chk1("sign2", div_sign_op_2_o, m_sign);
            end
            for (int i = 0; i < lit_n; i++) begin
                if (lit_cyc[i] == cyc) begin
                    case (lit_sel[i])
                        0: begin
                            chk1("lit_rvalid", result_valid_o, 1'b1);
                            chk("lit_result", result_o, lit_val[i]);
                        end
                        1: chk("lit_op1", div_op_1_o, lit_val[i]);
                        2: begin
                            chk("lit_zero_ctl", {60'd0, div_req_valid_o, div_sign_op_1_o, div_sign_op_2_o, result_valid_o}, 64'd0);
                            chk("lit_zero_op1", div_op_1_o, 64'd0);
                            chk("lit_zero_op2", div_op_2_o, 64'd0);
                            chk("lit_zero_res", result_o, 64'd0);
                        end
                        3: chk("lit_op2", div_op_2_o, lit_val[i]);
                        4: chk1("lit_stall", stall_o, lit_val[i][0]);
                        5: chk1("lit_req", div_req_valid_o, lit_val[i][0]);
                        default: chk("lit_sel", 64'(lit_sel[i]), 64'd0);
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic lit(input int c, input int sel, input logic [63:0] v);
        lit_cyc[lit_n] = c;
        lit_sel[lit_n] = sel;
        lit_val[lit_n] = v;
        lit_n = lit_n + 1;
    endtask

    // Present one instruction for a single cycle and record its expected timeline.
    task automatic start(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        logic sgn, spec;
        sgn = ~op[0];
        spec = word ? (b[31:0] == 32'd0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
                    : (b == 64'd0 || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        ex_valid_i = 1'b1; div_op_i = op; word_i = word; rs1_i = a; rs2_i = b;
        m_res  = ref_res(op, word, a, b);
        m_sign = sgn;
        m_op1  = word ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        m_op2  = word ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
        m_supp = 1'b0;
        m_blo  = cyc + 1;
        if (spec) begin
            m_issued = 1'b0; m_req = -1; m_bhi = cyc; m_done = cyc + 1; m_next = cyc + 2;
        end else begin
            m_issued = 1'b1; m_req = cyc + 1; m_bhi = cyc + 67; m_done = cyc + 68; m_next = cyc + 69;
        end
        tick();
        ex_valid_i = 1'b0; rs1_i = ~a; rs2_i = b + 64'd1; div_op_i = ~op; word_i = ~word;
    endtask

    int a;
    initial begin
        rst = 1'b1; ex_valid_i = 1'b0; flush_i = 1'b0; div_op_i = 2'b00; word_i = 1'b0;
        rs1_i = 64'd0; rs2_i = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        lit(cyc, 2, 64'd0);
        lit(cyc, 4, 64'd0);
        tick();

        // DIV 100/7, with ignored ex_valid_i traffic while busy
        a = cyc;
        lit(a + 1, 5, 64'd1); lit(a + 2, 5, 64'd0); lit(a + 67, 4, 64'd1); lit(a + 68, 4, 64'd0);
        lit(a + 68, 0, 64'd14);
        start(2'b00, 1'b0, 64'd100, 64'd7);
        repeat (2) tick();
        ex_valid_i = 1'b1; div_op_i = 2'b11; rs1_i = 64'd5; rs2_i = 64'd0;
        repeat (5) tick();
        ex_valid_i = 1'b0;
        run_to(m_next);

        // REMW -7 % 3
        a = cyc;
        lit(a + 1, 1, 64'hFFFF_FFFF_FFFF_FFF9); lit(a + 68, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        start(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3);
        run_to(m_next);

        // DIVU by zero
        a = cyc;
        lit(a + 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        start(2'b01, 1'b0, 64'd1234, 64'd0);
        run_to(m_next);

        // DIV and REM signed overflow
        a = cyc;
        lit(a + 1, 0, 64'h8000_0000_0000_0000);
        start(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run_to(m_next);
        a = cyc;
        lit(a + 1, 0, 64'd0);
        start(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run_to(m_next);

        // DIVW overflow and REMUW by zero, junk in upper words
        a = cyc;
        lit(a + 1, 0, 64'hFFFF_FFFF_8000_0000);
        start(2'b00, 1'b1, 64'hAAAA_AAAA_8000_0000, 64'h1234_5678_FFFF_FFFF);
        run_to(m_next);
        a = cyc;
        lit(a + 1, 0, 64'hFFFF_FFFF_9000_0001);
        start(2'b11, 1'b1, 64'h5555_5555_9000_0001, 64'hABCD_0000_0000_0000);
        run_to(m_next);

        // DIVUW with junk upper words, DIVW negative, REMU and DIV 64-bit
        a = cyc;
        lit(a + 1, 1, 64'h0000_0000_FFFF_FFFE); lit(a + 68, 0, 64'h0000_0000_7FFF_FFFF);
        start(2'b01, 1'b1, 64'hDEAD_0000_FFFF_FFFE, 64'h0000_0001_0000_0002);
        run_to(m_next);
        a = cyc;
        lit(a + 68, 0, 64'hFFFF_FFFF_FFFF_FFFB);
        start(2'b00, 1'b1, 64'h0000_0001_FFFF_FFF0, 64'd3);
        run_to(m_next);
        a = cyc;
        lit(a + 68, 0, 64'd6);
        start(2'b11, 1'b0, 64'd1000, 64'd7);
        run_to(m_next);
        a = cyc;
        lit(a + 68, 0, 64'hFFFF_FFFF_FFFF_FFF2);
        start(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        run_to(m_next);

        // Flush at +10 of DIVU 50/5, next instruction at +68
        a = cyc;
        lit(a + 40, 1, 64'd50); lit(a + 40, 3, 64'd5);
        start(2'b01, 1'b0, 64'd50, 64'd5);
        run_to(a + 10);
        flush_i = 1'b1; m_done = -1; m_next = a + 68;
        tick();
        flush_i = 1'b0;
        run_to(m_next);
        a = cyc;
        lit(a + 68, 0, 64'd2);
        start(2'b11, 1'b0, 64'd17, 64'd5);
        run_to(m_next);

        // Flush in ISSUE
        a = cyc;
        start(2'b00, 1'b0, 64'd81, 64'd9);
        flush_i = 1'b1; m_done = -1; m_next = a + 68;
        tick();
        flush_i = 1'b0;
        run_to(m_next);

        // Reset at +30 of DIV, then DIVU 9/2
        a = cyc;
        start(2'b00, 1'b0, 64'd100, 64'd7);
        run_to(a + 30);
        rst = 1'b1; m_bhi = a + 30; m_done = -1; m_next = a + 31;
        lit(a + 31, 2, 64'd0);
        tick();
        rst = 1'b0;
        a = cyc;
        lit(a + 68, 0, 64'd4);
        start(2'b01, 1'b0, 64'd9, 64'd2);
        run_to(m_next);

        // Flush in IDLE blocks acceptance
        lit(cyc, 4, 64'd1); lit(cyc + 1, 5, 64'd0); lit(cyc + 1, 4, 64'd0);
        ex_valid_i = 1'b1; flush_i = 1'b1; div_op_i = 2'b00; word_i = 1'b0; rs1_i = 64'd10; rs2_i = 64'd2;
        tick();
        ex_valid_i = 1'b0; flush_i = 1'b0;
        repeat (3) tick();

        // Flush in DONE suppresses the strobe; IDLE right after
        a = cyc;
        start(2'b01, 1'b0, 64'd77, 64'd0);
        flush_i = 1'b1; m_supp = 1'b1;
        tick();
        flush_i = 1'b0;
        a = cyc;
        lit(a + 1, 0, 64'd42);
        start(2'b11, 1'b0, 64'd42, 64'd0);
        run_to(m_next + 3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ex_valid_i  in  1  execute stage presents a divide/remainder instruction.
REQ-005 flush_i  in  1  pipeline flush; abandons the current instruction.
REQ-006 div_op_i  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 word_i  in  1  1 selects the 32-bit W variant (DIVW, DIVUW, REMW, REMUW).
REQ-008 rs1_i / rs2_i  in  64 each  dividend and divisor.
REQ-009 div_req_valid_o  out  1  request pulse to the divider.
REQ-010 div_op_1_o / div_op_2_o  out  64 each  divider operands.
REQ-011 div_sign_op_1_o / div_sign_op_2_o  out  1 each  signed-operand flags to the divider.
REQ-012 div_quotient_i / div_remainder_i  in  64 each  divider results.
REQ-013 div_ready_i / div_valid_i  in  1 each  divider status.
REQ-014 result_o  out  64  final registered result.
REQ-015 result_valid_o  out  1  one-cycle result strobe.
REQ-016 stall_o  out  1  holds the pipeline until the result is delivered.

Function
REQ-017 The FSM SHALL have five states: IDLE, ISSUE, WAIT, DRAIN and DONE.
REQ-018 IDLE with ex_valid_i=1 and flush_i=0 SHALL latch operands, div_op_i and word_i.
  - Special case (REQ-021): next state DONE.
  - Otherwise: next state ISSUE.
REQ-019 ISSUE SHALL drive div_req_valid_o=1 for exactly that cycle, then go to WAIT.
  - div_req_valid_o SHALL depend on FSM state only, never combinationally on div_ready_i or div_valid_i.
REQ-020 Operand formation:
  - Signed ops (DIV, REM): both sign flags = 1.
  - Unsigned ops (DIVU, REMU): both sign flags = 0.
  - word_i=1: operands are rs[31:0], sign-extended for signed ops and zero-extended for unsigned ops.
  - div_op_1_o, div_op_2_o and both sign flags SHALL hold constant from ISSUE until the divider completes, including during DRAIN.
REQ-021 Special cases SHALL be resolved locally without issuing to the divider:
  - Divisor zero: quotient = all ones; remainder = dividend (sign-extended from bit 31 if word_i).
  - Signed overflow (dividend most-negative, divisor -1, at 64 or 32 bits): quotient = dividend, remainder = 0.
REQ-022 In WAIT, the block SHALL capture the first div_valid_i=1.
  - Capture div_quotient_i for DIV/DIVU, div_remainder_i for REM/REMU.
  - word_i=1: result_o is sign-extended from bit 31.
  - Next state DONE.
REQ-023 div_valid_i SHALL be ignored in IDLE, ISSUE and DONE; the divider reports valid while idle, so that assertion is spurious.
REQ-024 DONE SHALL assert result_valid_o for one cycle with result_o stable, then go to IDLE.
REQ-025 stall_o = 1 in ISSUE, WAIT and DRAIN, and in IDLE when ex_valid_i=1; stall_o = 0 in DONE.
REQ-026 Latency:
  - Issued operation: result_valid_o 68 cycles after the IDLE accept cycle (ISSUE at +1, divider complete at +67, DONE at +68).
  - Special case: DONE at +1.
REQ-027 Flush in ISSUE or WAIT SHALL go to DRAIN, because the divider cannot abort. DRAIN waits for div_valid_i, discards the result, then goes to IDLE.
REQ-028 Flush in DONE SHALL suppress result_valid_o and go to IDLE.
REQ-029 Flush in IDLE SHALL block acceptance that cycle.
REQ-030 No new instruction SHALL be accepted outside IDLE; ex_valid_i SHALL be ignored in all other states.
REQ-031 result_o SHALL retain its last value between strobes.

Reset
REQ-032 rst=1 SHALL force IDLE and clear every output register to 0.
  - Cleared: div_req_valid_o, div_op_1_o, div_op_2_o, both sign flags, result_o, result_valid_o.
  - stall_o follows REQ-025.
REQ-033 Reset mid-operation SHALL return to IDLE immediately.
  - The divider shares rst and is reset in the same cycle.
  - No stale div_valid_i SHALL be captured after reset.

Verification
REQ-034 DIV rs1=100, rs2=7:
  - div_req_valid_o pulses once at +1 with sign flags 1.
  - result_valid_o at +68; result_o=14.
  - stall_o high from +0 through +67.
REQ-035 REMW rs1=0xFFFFFFFF_FFFFFFF9 (-7), rs2=3:
  - div_op_1_o = -7 sign-extended.
  - result_o = 0xFFFFFFFF_FFFFFFFF (-1).
REQ-036 DIVU rs2=0:
  - No div_req_valid_o.
  - result_valid_o at +1; result_o = 0xFFFFFFFF_FFFFFFFF.
REQ-037 DIV rs1=0x80000000_00000000, rs2=-1:
  - result_o = 0x80000000_00000000 at +1.
  - REM with the same operands gives result_o = 0.
REQ-038 Flush at +10 of DIVU 50/5:
  - FSM enters DRAIN; operands are held.
  - No result_valid_o; IDLE at +68; next instruction accepted at +68.
REQ-039 rst asserted at +30 of DIV:
  - All outputs 0 next cycle; no result_valid_o.
  - A new DIVU 9/2 gives result_o=4 at +68 after acceptance.
